// File: rtl/calc1_arb_pkg.sv
// Shared types and constants for the four-port calc1 ALU arbiter.
// The optional WAIT timeout (CALC1_ARB_TIMEOUT_EN) uses TIMEOUT_LIMIT and TimeoutCntW.
package calc1_arb_pkg;

  typedef enum logic [1:0] {
    IssIdle,
    IssIssue,
    IssWait,
    IssResp
  } iss_state_e;

  typedef enum logic [1:0] {
    PIdle,
    POp2,
    PPend
  } port_state_e;

  localparam int unsigned NumPorts = 4;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;
  localparam logic [1:0] RESP_INV  = 2'd3;

  localparam int unsigned TIMEOUT_LIMIT = 16;
  localparam int unsigned TimeoutCntW   = 5;

  // Round-robin successor; port 4 (index 3) wraps to port 1 (index 0).
  function automatic logic [1:0] next_port(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/calc1_port_capture.sv
// Per-port capture FSM: latches cmd/op1, then op2, then holds the request until released.
// op2 is forwarded while it is still on the data bus so the arbiter can grant one cycle early.
module calc1_port_capture
  import calc1_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic [31:0] data,
  input  logic        done,
  output logic        ready,
  output logic [3:0]  cap_cmd,
  output logic [31:0] cap_op1,
  output logic [31:0] cap_op2
);

  port_state_e state_q;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PIdle;
      cmd_q   <= 4'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
    end else begin
      case (state_q)
        PIdle: begin
          if (cmd != 4'd0) begin
            cmd_q   <= cmd;
            op1_q   <= data;
            state_q <= POp2;
          end
        end
        POp2: begin
          op2_q   <= data;
          state_q <= PPend;
        end
        PPend: begin
          // A command in the release cycle starts the next request directly.
          if (done) begin
            if (cmd != 4'd0) begin
              cmd_q   <= cmd;
              op1_q   <= data;
              state_q <= POp2;
            end else begin
              state_q <= PIdle;
            end
          end
        end
        default: state_q <= PIdle;
      endcase
    end
  end

  assign ready   = (state_q == POp2) || (state_q == PPend);
  assign cap_cmd = cmd_q;
  assign cap_op1 = op1_q;
  assign cap_op2 = (state_q == POp2) ? data : op2_q;

endmodule

// File: rtl/calc1_port_arbiter.sv
// Four-port round-robin arbiter in front of a shared ALU; all outputs are registered.
// Define CALC1_ARB_TIMEOUT_EN to bound the WAIT state with a timeout that answers RESP_ERR.
module calc1_port_arbiter
  import calc1_arb_pkg::*;
(
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic        alu_req_valid,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [1:0]  alu_resp,
  input  logic [31:0] alu_data
);

  logic [3:0]          cmd_in  [NumPorts];
  logic [31:0]         data_in [NumPorts];
  logic [NumPorts-1:0] ready;
  logic [NumPorts-1:0] done;
  logic [3:0]          cap_cmd [NumPorts];
  logic [31:0]         cap_op1 [NumPorts];
  logic [31:0]         cap_op2 [NumPorts];

  iss_state_e  iss_q;
  logic [1:0]  ptr_q;
  logic [1:0]  grant_q;
  logic [1:0]  resp_q  [NumPorts];
  logic [31:0] rdata_q [NumPorts];
`ifdef CALC1_ARB_TIMEOUT_EN
  logic [TimeoutCntW-1:0] tmo_cnt_q;
`endif

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  for (genvar g = 0; g < NumPorts; g++) begin : g_port
    assign done[g] = (iss_q == IssResp) && (grant_q == 2'(g));

    calc1_port_capture u_capture (
      .clk     (c_clk),
      .reset   (reset),
      .cmd     (cmd_in[g]),
      .data    (data_in[g]),
      .done    (done[g]),
      .ready   (ready[g]),
      .cap_cmd (cap_cmd[g]),
      .cap_op1 (cap_op1[g]),
      .cap_op2 (cap_op2[g])
    );
  end

  // Round-robin search starting at the pointer, upward with wrap.
  logic       sel_valid;
  logic [1:0] sel;
  logic [1:0] idx;

  always_comb begin
    sel_valid = 1'b0;
    sel       = ptr_q;
    idx       = ptr_q;
    for (int k = 0; k < NumPorts; k++) begin
      idx = ptr_q + 2'(k);
      if (!sel_valid && ready[idx]) begin
        sel_valid = 1'b1;
        sel       = idx;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      iss_q         <= IssIdle;
      ptr_q         <= 2'd0;
      grant_q       <= 2'd0;
      alu_req_valid <= 1'b0;
      alu_cmd       <= 4'd0;
      alu_op1       <= 32'd0;
      alu_op2       <= 32'd0;
      for (int i = 0; i < NumPorts; i++) begin
        resp_q[i]  <= RESP_NONE;
        rdata_q[i] <= 32'd0;
      end
`ifdef CALC1_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      case (iss_q)
        IssIdle: begin
          if (sel_valid) begin
            grant_q       <= sel;
            alu_req_valid <= 1'b1;
            alu_cmd       <= cap_cmd[sel];
            alu_op1       <= cap_op1[sel];
            alu_op2       <= cap_op2[sel];
            iss_q         <= IssIssue;
          end
        end
        IssIssue: begin
          ptr_q         <= next_port(grant_q);
          alu_req_valid <= 1'b0;
          alu_cmd       <= 4'd0;
          alu_op1       <= 32'd0;
          alu_op2       <= 32'd0;
          iss_q         <= IssWait;
`ifdef CALC1_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
`ifdef CALC1_ARB_TIMEOUT_EN
        IssWait: begin
          if (alu_resp != RESP_NONE) begin
            resp_q[grant_q]  <= alu_resp;
            rdata_q[grant_q] <= alu_data;
            iss_q            <= IssResp;
          end else if (tmo_cnt_q == TimeoutCntW'(TIMEOUT_LIMIT - 1)) begin
            resp_q[grant_q]  <= RESP_ERR;
            rdata_q[grant_q] <= 32'd0;
            iss_q            <= IssResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TimeoutCntW'(1);
          end
        end
`else
        IssWait: begin
          if (alu_resp != RESP_NONE) begin
            resp_q[grant_q]  <= alu_resp;
            rdata_q[grant_q] <= alu_data;
            iss_q            <= IssResp;
          end
        end
`endif
        IssResp: begin
          for (int i = 0; i < NumPorts; i++) begin
            resp_q[i]  <= RESP_NONE;
            rdata_q[i] <= 32'd0;
          end
          iss_q <= IssIdle;
        end
        default: iss_q <= IssIdle;
      endcase
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = rdata_q[0];
  assign out_data2 = rdata_q[1];
  assign out_data3 = rdata_q[2];
  assign out_data4 = rdata_q[3];

endmodule
